// File: rtl/hack_mem_io.sv
// hack_mem_io: Minimal-Hack data RAM with memory-mapped LED, debounced buttons and sticky edge flags.
// Define HACK_MEM_TIMER_EN to build the prescaled timer at address 8195.
module hack_mem_io #(
    parameter int DATA_W       = 16,
    parameter int RAM_AW       = 12,
    parameter int NUM_BUT      = 2,
    parameter int NUM_LED      = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TICK_DIV     = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        address,
    input  logic [DATA_W-1:0]  dataW,
    output logic [DATA_W-1:0]  dataR,
    input  logic               load,
    input  logic [NUM_BUT-1:0] but,
    output logic [NUM_LED-1:0] led
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [13:0]      A_LED   = 14'd8192;
    localparam logic [13:0]      A_BUT   = 14'd8193;
    localparam logic [13:0]      A_EDGE  = 14'd8194;
    localparam logic [13:0]      A_TIMER = 14'd8195;

    logic [13:0]        addr;
    logic               is_ram;
    logic               wr_ram;
    logic               wr_led;
    logic               wr_edge;
    logic               wr_timer;
    logic [DATA_W-1:0]  led_reg;
    logic [DATA_W-1:0]  timer_rd;
    logic [NUM_BUT-1:0] deb;
    logic [NUM_BUT-1:0] rise;
    logic [NUM_BUT-1:0] edge_flags;
    logic [NUM_BUT-1:0] edge_clr;
    logic               unused_addr;

    assign addr        = address[13:0];
    assign is_ram      = ~addr[13];
    assign wr_ram      = load & is_ram;
    assign wr_led      = load & (addr == A_LED);
    assign wr_edge     = load & (addr == A_EDGE);
    assign wr_timer    = load & (addr == A_TIMER);
    assign unused_addr = ^address[15:14];

    logic [DATA_W-1:0] ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[address[RAM_AW-1:0]] <= dataW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led_reg <= '0;
        else if (wr_led)
            led_reg <= dataW;
    end

    assign led = led_reg[NUM_LED-1:0];

    // Per button: two-flop synchroniser, then a counter that must see the new level
    // for DEBOUNCE_CYC consecutive edges before it is accepted.
    for (genvar i = 0; i < NUM_BUT; i++) begin : g_but
        logic             s1;
        logic             s2;
        logic             deb_r;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                deb_r <= 1'b0;
                cnt   <= '0;
            end else begin
                s1 <= but[i];
                s2 <= s1;
                if (s2 == deb_r) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    deb_r <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb[i]  = deb_r;
        assign rise[i] = s2 & ~deb_r & (cnt == CNT_MAX);
    end

    // A coincident set beats the write-1-clear.
    assign edge_clr = wr_edge ? dataW[NUM_BUT-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_flags <= '0;
        else
            edge_flags <= (edge_flags & ~edge_clr) | rise;
    end

`ifdef HACK_MEM_TIMER_EN
    localparam int               PRE_W   = $clog2(TICK_DIV) + 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre;
    logic [DATA_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            timer <= '0;
        end else if (wr_timer) begin
            pre   <= '0;
            timer <= dataW;
        end else if (pre == PRE_MAX) begin
            pre   <= '0;
            timer <= timer + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign timer_rd = timer;
`else
    logic unused_timer;

    assign unused_timer = wr_timer & (TICK_DIV > 0);
    assign timer_rd     = '0;
`endif

    always_comb begin
        dataR = '0;
        if (is_ram) begin
            dataR = ram[address[RAM_AW-1:0]];
        end else begin
            case (addr)
                A_LED:   dataR = led_reg;
                A_BUT:   dataR = DATA_W'(deb);
                A_EDGE:  dataR = DATA_W'(edge_flags);
                A_TIMER: dataR = timer_rd;
                default: dataR = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_mem_io.sv
// Self-checking bench for hack_mem_io: expected read values are queued as stimulus is driven
// and popped as the DUT is read back. Timer expectations follow HACK_MEM_TIMER_EN.
module tb_hack_mem_io;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] dataW = '0;
    logic [15:0] dataR;
    logic        load = 1'b0;
    logic [1:0]  but = '0;
    logic [7:0]  led;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    hack_mem_io #(
        .DATA_W(16), .RAM_AW(12), .NUM_BUT(2), .NUM_LED(8),
        .DEBOUNCE_CYC(4), .TICK_DIV(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .dataW(dataW),
        .dataR(dataR), .load(load), .but(but), .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a);
        address = a;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        dataW   = d;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({8'h00, led} !== exp_v) begin n_err++; $display("FAIL rst_led: got %h want %h", led, exp_v); end
        rd(16'd8192); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL rst_ledreg: got %h want %h", dataR, exp_v); end
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL rst_but: got %h want %h", dataR, exp_v); end
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL rst_edge: got %h want %h", dataR, exp_v); end
        rd(16'd8195); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL rst_timer: got %h want %h", dataR, exp_v); end
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_ram();
        wr(16'd5, 16'h1234);    exp_q.push_back(16'h1234);
        wr(16'd4095, 16'hBEEF); exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h1234);
        address = 16'd5; dataW = 16'hDEAD; load = 1'b0;
        step(1);
        exp_q.push_back(16'h1234);
        rd(16'd5); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_5: got %h want %h", dataR, exp_v); end
        rd(16'd4095); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_4095: got %h want %h", dataR, exp_v); end
        rd(16'd4101); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_alias: got %h want %h", dataR, exp_v); end
        rd(16'd5); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_noload: got %h want %h", dataR, exp_v); end
        // read-during-write shows the old word until the edge
        address = 16'd5; dataW = 16'h5678; load = 1'b1;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_rdw_old: got %h want %h", dataR, exp_v); end
        step(1); load = 1'b0;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ram_rdw_new: got %h want %h", dataR, exp_v); end
    endtask

    task automatic test_timer();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        address = 16'd8195;
`ifdef HACK_MEM_TIMER_EN
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h5555);
`else
        repeat (7) exp_q.push_back(16'h0000);
`endif
        step(2); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_e2: got %h want %h", dataR, exp_v); end
        step(1); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_e3: got %h want %h", dataR, exp_v); end
        step(3); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_e6: got %h want %h", dataR, exp_v); end
        wr(16'd8195, 16'hFFFF); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_load: got %h want %h", dataR, exp_v); end
        step(2); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_load2: got %h want %h", dataR, exp_v); end
        step(1); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_wrap: got %h want %h", dataR, exp_v); end
        wr(16'd8195, 16'h5555); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL tmr_5555: got %h want %h", dataR, exp_v); end
    endtask

    task automatic test_debounce();
        but[0] = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        step(5);
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL deb_e5: got %h want %h", dataR, exp_v); end
        step(1);
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL deb_e6: got %h want %h", dataR, exp_v); end
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL deb_edge: got %h want %h", dataR, exp_v); end
        step(1);
        but[1] = 1'b1;
        step(3);
        but[1] = 1'b0;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        step(10);
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL glitch_but: got %h want %h", dataR, exp_v); end
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL glitch_edge: got %h want %h", dataR, exp_v); end
    endtask

    task automatic test_edge_clear();
        but[1] = 1'b1;
        exp_q.push_back(16'h0003); exp_q.push_back(16'h0003);
        step(8);
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL clr_pre: got %h want %h", dataR, exp_v); end
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL clr_but: got %h want %h", dataR, exp_v); end
        wr(16'd8194, 16'h0001); exp_q.push_back(16'h0002);
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL clr_bit0: got %h want %h", dataR, exp_v); end
        wr(16'd8193, 16'h0000); exp_q.push_back(16'h0003);
        rd(16'd8193); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL but_ro: got %h want %h", dataR, exp_v); end
        but[1] = 1'b0;
        step(8);
        wr(16'd8194, 16'h0002); exp_q.push_back(16'h0000);
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL clr_bit1: got %h want %h", dataR, exp_v); end
        but[1] = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0002); exp_q.push_back(16'h0002);
        step(5);
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL setwin_pre: got %h want %h", dataR, exp_v); end
        // clear of bit 1 lands on the edge deb[1] rises
        wr(16'd8194, 16'h0002);
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL setwin: got %h want %h", dataR, exp_v); end
        address = 16'd8194; dataW = 16'h0003; load = 1'b0;
        step(1);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL clr_noload: got %h want %h", dataR, exp_v); end
    endtask

    task automatic test_unmapped();
        wr(16'd8192, 16'h00C3);
        wr(16'd8195, 16'h0100);
        wr(16'd9000, 16'hFFFF);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h00C3); exp_q.push_back(16'h0002);
`ifdef HACK_MEM_TIMER_EN
        exp_q.push_back(16'h0100);
`else
        exp_q.push_back(16'h0000);
`endif
        rd(16'd9000); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL unm_rd: got %h want %h", dataR, exp_v); end
        rd(16'd8192); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL unm_led: got %h want %h", dataR, exp_v); end
        rd(16'd8194); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL unm_edge: got %h want %h", dataR, exp_v); end
        rd(16'd8195); exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL unm_timer: got %h want %h", dataR, exp_v); end
    endtask

    task automatic test_led();
        step(1);
        address = 16'd8192; dataW = 16'h01A5; load = 1'b1;
        exp_q.push_back(16'h00C3); exp_q.push_back(16'h00A5); exp_q.push_back(16'h01A5);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL led_rdw: got %h want %h", dataR, exp_v); end
        step(1); load = 1'b0;
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({8'h00, led} !== exp_v) begin n_err++; $display("FAIL led_pins: got %h want %h", led, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL led_reg: got %h want %h", dataR, exp_v); end
        #2;
        rst_n = 1'b0;
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({8'h00, led} !== exp_v) begin n_err++; $display("FAIL led_async_rst: got %h want %h", led, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (dataR !== exp_v) begin n_err++; $display("FAIL ledreg_async_rst: got %h want %h", dataR, exp_v); end
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_timer();
        test_debounce();
        test_edge_clear();
        test_unmapped();
        test_led();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
